psram_sched: RTL and testbench

PSRAM_SCHED -- requirements
Module: psram_sched

---
 rtl/psram_sched.sv | 216 +++++++++++++++++++++
 tb/tb_psram_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_sched.sv
// psram_sched: arbitrates the config port and two bus masters onto a
// single PSRAM core transfer port, issuing a global reset on enable.
module psram_sched #(
    parameter logic [7:0]  RST_CMD = 8'hFF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cfg_en_i,
    output logic             init_done_o,
    input  logic             cmd_req_i,
    input  logic             cmd_rdwr_i,
    input  logic [7:0]       cmd_ccmd_i,
    output logic             cmd_ack_o,
    input  logic             m0_valid_i,
    input  logic             m0_rdwr_i,
    input  logic [31:0]      m0_addr_i,
    input  logic [63:0]      m0_wdata_i,
    input  logic [7:0]       m0_wmask_i,
    output logic             m0_ready_o,
    output logic [63:0]      m0_rdata_o,
    input  logic             m1_valid_i,
    input  logic             m1_rdwr_i,
    input  logic [31:0]      m1_addr_i,
    input  logic [63:0]      m1_wdata_i,
    input  logic [7:0]       m1_wmask_i,
    output logic             m1_ready_o,
    output logic [63:0]      m1_rdata_o,
    output logic             core_valid_o,
    output logic             core_rdwr_o,
    output logic             core_cflg_o,
    output logic [7:0]       core_ccmd_o,
    output logic [31:0]      core_addr_o,
    output logic [63:0]      core_wdata_o,
    output logic [7:0]       core_wmask_o,
    input  logic             core_ready_i,
    input  logic             core_done_i,
    input  logic [63:0]      core_rdata_i,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    typedef enum logic [2:0] {
        OFF,
        INIT_ISS,
        INIT_WAIT,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_CMD,
        G_M0,
        G_M1
    } gnt_t;

    state_t state_q;
    state_t state_d;
    gnt_t   gnt_q;
    gnt_t   pick;
    logic   last_m1_q;
    logic   abort_q;
    logic   stop;
    logic   in_xfer;

    // A disable seen during a transfer is remembered until it drains
    assign stop    = abort_q || !cfg_en_i;
    assign in_xfer = (state_q == INIT_ISS)  || (state_q == INIT_WAIT) ||
                     (state_q == ISSUE)     || (state_q == WAIT);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= OFF;
        else          state_q <= state_d;
    end

    // Next state, grant selection and the one-cycle core request
    always_comb begin
        state_d      = state_q;
        pick         = G_NONE;
        core_valid_o = 1'b0;
        unique case (state_q)
            OFF: begin
                if (cfg_en_i) state_d = INIT_ISS;
            end
            INIT_ISS: begin
                if (core_ready_i) begin
                    core_valid_o = 1'b1;
                    state_d      = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (core_done_i) state_d = stop ? OFF : IDLE;
            end
            IDLE: begin
                if (!cfg_en_i) begin
                    state_d = OFF;
                end else begin
                    if (cmd_req_i)
                        pick = G_CMD;
                    else if (m0_valid_i && m1_valid_i)
                        pick = last_m1_q ? G_M0 : G_M1;
                    else if (m0_valid_i)
                        pick = G_M0;
                    else if (m1_valid_i)
                        pick = G_M1;
                    if (pick != G_NONE) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready_i) begin
                    core_valid_o = 1'b1;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (core_done_i) state_d = stop ? OFF : IDLE;
            end
            default: state_d = OFF;
        endcase
    end

    // Attribute latching, completions, read data and transfer count
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gnt_q        <= G_NONE;
            last_m1_q    <= 1'b1;
            abort_q      <= 1'b0;
            init_done_o  <= 1'b0;
            cmd_ack_o    <= 1'b0;
            m0_ready_o   <= 1'b0;
            m1_ready_o   <= 1'b0;
            m0_rdata_o   <= '0;
            m1_rdata_o   <= '0;
            core_rdwr_o  <= 1'b0;
            core_cflg_o  <= 1'b0;
            core_ccmd_o  <= '0;
            core_addr_o  <= '0;
            core_wdata_o <= '0;
            core_wmask_o <= '0;
            xfer_cnt_o   <= '0;
        end else begin
            cmd_ack_o  <= 1'b0;
            m0_ready_o <= 1'b0;
            m1_ready_o <= 1'b0;
            abort_q    <= (state_d != OFF) &&
                          (abort_q || (in_xfer && !cfg_en_i));

            if (state_d == OFF)
                init_done_o <= 1'b0;
            else if (state_q == INIT_WAIT && core_done_i)
                init_done_o <= 1'b1;

            if (state_q == OFF && cfg_en_i) begin
                gnt_q        <= G_NONE;
                core_rdwr_o  <= 1'b0;
                core_cflg_o  <= 1'b1;
                core_ccmd_o  <= RST_CMD;
                core_addr_o  <= '0;
                core_wdata_o <= '0;
                core_wmask_o <= '0;
            end

            unique case (pick)
                G_CMD: begin
                    gnt_q        <= G_CMD;
                    core_rdwr_o  <= cmd_rdwr_i;
                    core_cflg_o  <= 1'b1;
                    core_ccmd_o  <= cmd_ccmd_i;
                    core_addr_o  <= '0;
                    core_wdata_o <= '0;
                    core_wmask_o <= '0;
                end
                G_M0: begin
                    gnt_q        <= G_M0;
                    last_m1_q    <= 1'b0;
                    core_rdwr_o  <= m0_rdwr_i;
                    core_cflg_o  <= 1'b0;
                    core_ccmd_o  <= '0;
                    core_addr_o  <= m0_addr_i;
                    core_wdata_o <= m0_wdata_i;
                    core_wmask_o <= m0_wmask_i;
                end
                G_M1: begin
                    gnt_q        <= G_M1;
                    last_m1_q    <= 1'b1;
                    core_rdwr_o  <= m1_rdwr_i;
                    core_cflg_o  <= 1'b0;
                    core_ccmd_o  <= '0;
                    core_addr_o  <= m1_addr_i;
                    core_wdata_o <= m1_wdata_i;
                    core_wmask_o <= m1_wmask_i;
                end
                default: ;
            endcase

            if (state_q == WAIT && core_done_i) begin
                xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
                unique case (gnt_q)
                    G_CMD: cmd_ack_o <= 1'b1;
                    G_M0: begin
                        m0_ready_o <= 1'b1;
                        m0_rdata_o <= core_rdata_i;
                    end
                    G_M1: begin
                        m1_ready_o <= 1'b1;
                        m1_rdata_o <= core_rdata_i;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_sched.sv
// tb_psram_sched: directed checks of init, arbitration, completion,
// disable draining and counter wrap with a simple core responder.
module tb_psram_sched;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          cfg_en_i;
    logic          init_done_o;
    logic          cmd_req_i;
    logic          cmd_rdwr_i;
    logic [7:0]    cmd_ccmd_i;
    logic          cmd_ack_o;
    logic          m0_valid_i, m1_valid_i;
    logic          m0_rdwr_i, m1_rdwr_i;
    logic [31:0]   m0_addr_i, m1_addr_i;
    logic [63:0]   m0_wdata_i, m1_wdata_i;
    logic [7:0]    m0_wmask_i, m1_wmask_i;
    logic          m0_ready_o, m1_ready_o;
    logic [63:0]   m0_rdata_o, m1_rdata_o;
    logic          core_valid_o;
    logic          core_rdwr_o;
    logic          core_cflg_o;
    logic [7:0]    core_ccmd_o;
    logic [31:0]   core_addr_o;
    logic [63:0]   core_wdata_o;
    logic [7:0]    core_wmask_o;
    logic          core_ready_i;
    logic          core_done_i;
    logic [63:0]   core_rdata_i;
    logic [CW-1:0] xfer_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    psram_sched #(.RST_CMD(8'hFF), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .cfg_en_i(cfg_en_i),
        .init_done_o(init_done_o),
        .cmd_req_i(cmd_req_i), .cmd_rdwr_i(cmd_rdwr_i),
        .cmd_ccmd_i(cmd_ccmd_i), .cmd_ack_o(cmd_ack_o),
        .m0_valid_i(m0_valid_i), .m0_rdwr_i(m0_rdwr_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wmask_i(m0_wmask_i), .m0_ready_o(m0_ready_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i), .m1_rdwr_i(m1_rdwr_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wmask_i(m1_wmask_i), .m1_ready_o(m1_ready_o),
        .m1_rdata_o(m1_rdata_o),
        .core_valid_o(core_valid_o), .core_rdwr_o(core_rdwr_o),
        .core_cflg_o(core_cflg_o), .core_ccmd_o(core_ccmd_o),
        .core_addr_o(core_addr_o), .core_wdata_o(core_wdata_o),
        .core_wmask_o(core_wmask_o), .core_ready_i(core_ready_i),
        .core_done_i(core_done_i), .core_rdata_i(core_rdata_i),
        .xfer_cnt_o(xfer_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for one core request, checks its attributes, holds it for
    // lat cycles, then returns done with rd.
    task automatic core_xfer(input string tag, input logic [63:0] rd,
                             input int lat, input logic exp_cflg,
                             input logic [7:0] exp_ccmd,
                             input logic exp_rdwr,
                             input logic [31:0] exp_addr,
                             input bit drop_en);
        int n;
        n = 0;
        @(negedge clk);
        while (!core_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(core_valid_o), 64'(1));
        if (!core_valid_o) return;
        check({tag, "_cflg"}, 64'(core_cflg_o), 64'(exp_cflg));
        check({tag, "_ccmd"}, 64'(core_ccmd_o), 64'(exp_ccmd));
        check({tag, "_rdwr"}, 64'(core_rdwr_o), 64'(exp_rdwr));
        check({tag, "_addr"}, 64'(core_addr_o), 64'(exp_addr));
        @(posedge clk);
        #1 core_ready_i = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (drop_en && i == 0) cfg_en_i = 1'b0;
            @(negedge clk);
            check({tag, "_hold_v"}, 64'(core_valid_o), 64'(0));
            check({tag, "_hold_cf"}, 64'(core_cflg_o), 64'(exp_cflg));
            check({tag, "_hold_rw"}, 64'(core_rdwr_o), 64'(exp_rdwr));
        end
        core_rdata_i = rd;
        core_done_i  = 1'b1;
        @(posedge clk);
        #1;
        core_done_i  = 1'b0;
        core_ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n_i = 1'b0; cfg_en_i = 1'b0;
        cmd_req_i = 1'b0; cmd_rdwr_i = 1'b0; cmd_ccmd_i = 8'h00;
        m0_valid_i = 1'b0; m0_rdwr_i = 1'b0; m0_addr_i = '0;
        m0_wdata_i = '0; m0_wmask_i = '0;
        m1_valid_i = 1'b0; m1_rdwr_i = 1'b0; m1_addr_i = '0;
        m1_wdata_i = '0; m1_wmask_i = '0;
        core_ready_i = 1'b1; core_done_i = 1'b0; core_rdata_i = '0;

        repeat (2) @(negedge clk);
        check("rst_init_done", 64'(init_done_o), 64'(0));
        check("rst_valid", 64'(core_valid_o), 64'(0));
        check("rst_cnt", 64'(xfer_cnt_o), 64'(0));
        check("rst_cflg", 64'(core_cflg_o), 64'(0));
        check("rst_ccmd", 64'(core_ccmd_o), 64'(0));
        check("rst_m0_rdata", m0_rdata_o, 64'(0));
        @(posedge clk);
        #1 rst_n_i = 1'b1;

        repeat (3) @(negedge clk);
        check("off_valid", 64'(core_valid_o), 64'(0));

        // Init global reset
        @(posedge clk);
        #1 cfg_en_i = 1'b1;
        core_xfer("init", 64'h0, 2, 1'b1, 8'hFF, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("init_done", 64'(init_done_o), 64'(1));
        check("init_cnt", 64'(xfer_cnt_o), 64'(0));
        check("init_no_ack", 64'(cmd_ack_o), 64'(0));

        // Single m0 read
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b1; m0_addr_i = 32'h0000_0100;
        core_xfer("m0rd", 64'hDEAD_BEEF_0123_4567, 2, 1'b0, 8'h00,
                  1'b1, 32'h0000_0100, 1'b0);
        m0_valid_i = 1'b0;
        @(negedge clk);
        check("m0rd_ready", 64'(m0_ready_o), 64'(1));
        check("m0rd_m1_ready", 64'(m1_ready_o), 64'(0));
        check("m0rd_rdata", m0_rdata_o, 64'hDEAD_BEEF_0123_4567);
        check("m0rd_cnt", 64'(xfer_cnt_o), 64'(1));
        @(negedge clk);
        check("m0rd_pulse1", 64'(m0_ready_o), 64'(0));
        check("m0rd_no_regrant", 64'(core_valid_o), 64'(0));

        // Single m1 write
        m1_valid_i = 1'b1; m1_rdwr_i = 1'b0; m1_addr_i = 32'h0000_0080;
        m1_wdata_i = 64'h1122_3344_5566_7788; m1_wmask_i = 8'h0F;
        core_xfer("m1wr", 64'h0, 1, 1'b0, 8'h00, 1'b0,
                  32'h0000_0080, 1'b0);
        m1_valid_i = 1'b0;
        @(negedge clk);
        check("m1wr_ready", 64'(m1_ready_o), 64'(1));
        check("m1wr_wdata", core_wdata_o, 64'h1122_3344_5566_7788);
        check("m1wr_wmask", 64'(core_wmask_o), 64'(8'h0F));
        check("m1wr_cnt", 64'(xfer_cnt_o), 64'(2));

        // Round robin with both masters held
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b1; m0_addr_i = 32'h0000_0200;
        m1_valid_i = 1'b1; m1_rdwr_i = 1'b1; m1_addr_i = 32'h0000_0300;
        core_xfer("rr0", 64'h11, 1, 1'b0, 8'h00, 1'b1, 32'h200, 1'b0);
        @(negedge clk);
        check("rr0_m0_ready", 64'(m0_ready_o), 64'(1));
        core_xfer("rr1", 64'h22, 1, 1'b0, 8'h00, 1'b1, 32'h300, 1'b0);
        @(negedge clk);
        check("rr1_m1_ready", 64'(m1_ready_o), 64'(1));
        core_xfer("rr2", 64'h33, 1, 1'b0, 8'h00, 1'b1, 32'h200, 1'b0);
        @(negedge clk);
        check("rr2_m0_ready", 64'(m0_ready_o), 64'(1));
        core_xfer("rr3", 64'h44, 1, 1'b0, 8'h00, 1'b1, 32'h300, 1'b0);
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        @(negedge clk);
        check("rr3_m1_ready", 64'(m1_ready_o), 64'(1));
        check("rr_m0_rdata", m0_rdata_o, 64'h33);
        check("rr_m1_rdata", m1_rdata_o, 64'h44);
        check("rr_cnt", 64'(xfer_cnt_o), 64'(6));

        // cmd, m0 and m1 together: cmd first, then m0, then m1
        @(posedge clk);
        #1;
        cmd_req_i = 1'b1; cmd_rdwr_i = 1'b0; cmd_ccmd_i = 8'hA5;
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b0; m0_addr_i = 32'h400;
        m1_valid_i = 1'b1; m1_rdwr_i = 1'b1; m1_addr_i = 32'h500;
        core_xfer("cmd", 64'h0, 3, 1'b1, 8'hA5, 1'b0, 32'h0, 1'b0);
        cmd_req_i = 1'b0;
        @(negedge clk);
        check("cmd_ack", 64'(cmd_ack_o), 64'(1));
        check("cmd_m0_ready", 64'(m0_ready_o), 64'(0));
        core_xfer("cm0", 64'h0, 1, 1'b0, 8'h00, 1'b0, 32'h400, 1'b0);
        m0_valid_i = 1'b0;
        @(negedge clk);
        check("cm0_ready", 64'(m0_ready_o), 64'(1));
        core_xfer("cm1", 64'h55, 1, 1'b0, 8'h00, 1'b1, 32'h500, 1'b0);
        m1_valid_i = 1'b0;
        @(negedge clk);
        check("cm1_ready", 64'(m1_ready_o), 64'(1));
        check("cmd_cnt", 64'(xfer_cnt_o), 64'(9));

        // Disable while in WAIT
        m1_valid_i = 1'b1; m1_rdwr_i = 1'b1; m1_addr_i = 32'h600;
        core_xfer("dis", 64'h66, 3, 1'b0, 8'h00, 1'b1, 32'h600, 1'b1);
        m1_valid_i = 1'b0;
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b1; m0_addr_i = 32'h700;
        @(negedge clk);
        check("dis_m1_ready", 64'(m1_ready_o), 64'(1));
        check("dis_m1_rdata", m1_rdata_o, 64'h66);
        check("dis_init_done", 64'(init_done_o), 64'(0));
        check("dis_cnt", 64'(xfer_cnt_o), 64'(10));
        repeat (3) @(negedge clk);
        check("off_no_grant", 64'(core_valid_o), 64'(0));
        check("off_no_ready", 64'(m0_ready_o), 64'(0));
        m0_valid_i = 1'b0;

        // Re-enable re-runs init, not counted
        @(posedge clk);
        #1 cfg_en_i = 1'b1;
        core_xfer("reinit", 64'h0, 1, 1'b1, 8'hFF, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("reinit_done", 64'(init_done_o), 64'(1));
        check("reinit_cnt", 64'(xfer_cnt_o), 64'(10));

        // Counter up to all-ones, then wrap
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b0; m0_addr_i = 32'h800;
        for (int k = 0; k < 5; k++)
            core_xfer("wr", 64'h0, 0, 1'b0, 8'h00, 1'b0, 32'h800, 1'b0);
        @(negedge clk);
        check("cnt_max", 64'(xfer_cnt_o), 64'(15));
        core_xfer("wrap", 64'h0, 0, 1'b0, 8'h00, 1'b0, 32'h800, 1'b0);
        m0_valid_i = 1'b0;
        @(negedge clk);
        check("cnt_wrap", 64'(xfer_cnt_o), 64'(0));

        // Stray done in IDLE is ignored
        @(posedge clk);
        #1 core_done_i = 1'b1;
        @(posedge clk);
        #1 core_done_i = 1'b0;
        @(negedge clk);
        check("stray_cnt", 64'(xfer_cnt_o), 64'(0));
        check("stray_ready", 64'(m0_ready_o), 64'(0));
        check("stray_ack", 64'(cmd_ack_o), 64'(0));

        // Reset mid-transfer gives no completion
        m0_valid_i = 1'b1; m0_rdwr_i = 1'b1; m0_addr_i = 32'h900;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!core_valid_o && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("rstx_valid", 64'(core_valid_o), 64'(1));
        end
        @(posedge clk);
        #1 core_ready_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b0;
        core_done_i = 1'b1;
        @(posedge clk);
        #1 core_done_i = 1'b0;
        core_ready_i = 1'b1;
        m0_valid_i = 1'b0;
        rst_n_i = 1'b1;
        @(negedge clk);
        check("rstx_ready", 64'(m0_ready_o), 64'(0));
        check("rstx_init_done", 64'(init_done_o), 64'(0));
        check("rstx_addr", 64'(core_addr_o), 64'(0));
        check("rstx_rdata", m0_rdata_o, 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
